lane_stripe_sched: RTL and testbench
====================================

# lane_stripe_sched

Scheduler for the two-lane byte-striping datapath of the PCIe physical layer, running in the `clk_2f` domain. It accepts 32-bit words from the upstream interface and decides, word by word, which lane receives each one. It tracks per-lane credits from the downstream lane FIFOs and applies backpressure. It keeps lane 0 and lane 1 pair-aligned and supports single-lane operation when only one lane is enabled.

## Interface
- `DW`, 32, data word width
- `CREDITS`, 4, per-lane downstream FIFO depth, range 1..15
- `PAD_WORD`, 32'hBCBCBCBC, filler word used to close an open pair
- `clk_2f`  in  1  double-rate clock; the only clock
- `reset_L`  in  1  synchronous, active-low reset; sampled on `clk_2f` rising edge
- `valid_in`  in  1  upstream word valid
- `data_in`  in  DW  upstream word
- `lane_en`  in  2  lane enable mask; bit0 = lane 0, bit1 = lane 1
- `credit_ret0` / `credit_ret1`  in  1  one credit returned by lane FIFO 0 / 1
- `ready_out`  out  1  word on `data_in` is accepted this edge if `valid_in` is also high
- `wr_en0` / `wr_en1`  out  1  registered write strobe to lane 0 / 1
- `data_out0` / `data_out1`  out  DW  registered lane data
- `pad_out`  out  1  current lane write carries `PAD_WORD`
- `err_credit`  out  1  sticky flag: a credit was returned while the counter was already at `CREDITS`

## Operation
- State machine: IDLE, STRIPE, SINGLE, FLUSH.
- `lane_en` is sampled only in IDLE. Changes in any other state take effect after the block returns to IDLE.
- IDLE transitions:
  - `lane_en`=2'b11 → STRIPE, with the lane pointer at lane 0.
  - 2'b01 or 2'b10 → SINGLE, targeting the enabled lane.
  - 2'b00 → stay in IDLE with `ready_out`=0.
- STRIPE:
  - Each accepted word goes to the lane selected by the pointer, then the pointer toggles.
  - With the pointer at lane 0 and `valid_in`=0 → IDLE.
  - With the pointer at lane 1 (pair open) and `valid_in`=0 → FLUSH, only when `STRIPE_PAD_EN` is defined.
- FLUSH:
  - If lane 1 has credit: write `PAD_WORD` to lane 1 with `pad_out`=1, set the pointer to lane 0, go to IDLE.
  - If lane 1 has no credit: wait in FLUSH.
- SINGLE: every accepted word goes to the enabled lane. Go to IDLE when `valid_in`=0.
- `ready_out` = state is STRIPE or SINGLE, and the target lane's credit is nonzero. It is 0 in IDLE and FLUSH. It is combinational from state and credits, never from `valid_in`.
- Credit counters:
  - Width 4. Reset to `CREDITS`.
  - Decrement on each write to the lane, including pad writes. Increment on `credit_ret`.
  - Write and return in the same cycle: counter unchanged.
  - Return while at `CREDITS` with no write: counter stays, `err_credit` set.
  - A write at zero credit is impossible by construction.

## Timing
- Word accepted at edge N (`valid_in`&`ready_out`) → `wr_enX`/`data_outX` valid in cycle N+1, high for exactly one cycle.
- Pad write: FLUSH entered at edge N, pad strobe in cycle N+1 if credit is available.
- Sustained throughput in STRIPE is 1 word per `clk_2f`, alternating lanes, while both lanes have credit. Each lane therefore sees 1 word per `clk_f`.
- Reset values:
  - state IDLE, pointer lane 0
  - `wr_en0`=`wr_en1`=0, `data_out0`=`data_out1`=0
  - `pad_out`=0, `err_credit`=0, `ready_out`=0
  - both credit counters = `CREDITS`
- Reset mid-pair:
  - No pad is emitted and the pointer returns to lane 0.
  - Any strobe pending from the previous edge is cleared.
- Credit exhaustion on lane 1 with the pointer at lane 1: `ready_out`=0 and the pointer holds. Lane 0 is not served out of order.

## Configuration
- `STRIPE_PAD_EN` defined:
  - An open pair is closed by FLUSH as above, so both lanes always carry equal word counts at each IDLE entry.
- `STRIPE_PAD_EN` not defined:
  - FLUSH is removed. In STRIPE with the pointer at lane 1 and `valid_in`=0, the block stays in STRIPE holding the pointer.
  - The next valid word goes to lane 1. `pad_out` is tied 0.

## Test plan
- Reset: `reset_L`=0 for 2 cycles with `valid_in`=1 → all strobes 0, `ready_out`=0, credits=4 after release.
- Stripe, `lane_en`=11: words AAAAAAAA, EEEEEEEE, CCCCCCCC, 11111111 back-to-back → lane 0 gets AAAAAAAA then CCCCCCCC, lane 1 gets EEEEEEEE then 11111111, each one cycle after acceptance.
- Backpressure: no credit returns, `CREDITS`=4, 10 valid words → exactly 8 accepted, `ready_out` low from the 9th word onward. One `credit_ret0` pulse → exactly one more word accepted.
- Open pair, `STRIPE_PAD_EN` on: single word 99999999 then `valid_in`=0 → lane 0 gets 99999999, then lane 1 gets BCBCBCBC with `pad_out`=1, then IDLE.
- Single lane, `lane_en`=10: words FFFFFFFF, AAAAAAAA → both on lane 1, `wr_en0` never asserted.
- Credit overflow: `credit_ret0` pulsed with the counter at 4 → `err_credit`=1 and stays 1 until reset. Simultaneous write and return on lane 0 → counter unchanged.

Source files
------------

// File: rtl/lane_stripe_if.sv
// lane_stripe_if: upstream word handshake, lane credit returns and lane write outputs of the stripe scheduler
// Ports (slave view): in valid_in, data_in[DW], lane_en[2], credit_ret0/1;
//                     out ready_out, wr_en0/1, data_out0/1[DW], pad_out, err_credit
interface lane_stripe_if #(parameter int DW = 32);
  logic valid_in;
  logic [DW-1:0] data_in;
  logic [1:0] lane_en;
  logic credit_ret0;
  logic credit_ret1;
  logic ready_out;
  logic wr_en0;
  logic wr_en1;
  logic [DW-1:0] data_out0;
  logic [DW-1:0] data_out1;
  logic pad_out;
  logic err_credit;
  modport master (
    output valid_in, data_in, lane_en, credit_ret0, credit_ret1,
    input ready_out, wr_en0, wr_en1, data_out0, data_out1, pad_out, err_credit
  );
  modport slave (
    input valid_in, data_in, lane_en, credit_ret0, credit_ret1,
    output ready_out, wr_en0, wr_en1, data_out0, data_out1, pad_out, err_credit
  );
endinterface

// File: rtl/lane_stripe_sched.sv
// lane_stripe_sched: two-lane word striping scheduler with per-lane credits, pair alignment and single-lane mode
// Ports: clk_2f (only clock), reset_L (sync active-low), bus (lane_stripe_if.slave: upstream
//        valid/data/ready, lane_en mask, credit returns, registered lane strobes/data, pad_out, err_credit)
// Config: define STRIPE_PAD_EN to close an open pair with PAD_WORD on lane 1 before returning to IDLE
module lane_stripe_sched #(
  parameter int DW = 32,
  parameter int CREDITS = 4,
  parameter logic [DW-1:0] PAD_WORD = 32'hBCBCBCBC
) (
  input logic clk_2f,
  input logic reset_L,
  lane_stripe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STRIPE, SINGLE, FLUSH} state_t;
  localparam logic [3:0] CMAX = 4'(CREDITS);
  state_t r_state, w_state_nxt;
  logic r_ptr, w_ptr_nxt;
  logic [3:0] r_cred0, r_cred1;
  logic r_wr0, r_wr1, r_pad, r_err;
  logic [DW-1:0] r_d0, r_d1;
  logic w_ready, w_acc, w_wr0, w_wr1, w_pad, w_ovf0, w_ovf1;
  function automatic logic [3:0] cred_nxt(input logic [3:0] c, input logic wr, input logic ret);
    return (wr == ret || (ret && c == CMAX)) ? c : wr ? c - 4'd1 : c + 4'd1;
  endfunction
  // r_ptr doubles as the stripe pointer and the single-lane target
  assign w_ready = (r_state == STRIPE || r_state == SINGLE) && (r_ptr ? |r_cred1 : |r_cred0);
  assign w_acc = bus.valid_in && w_ready;
  assign w_wr0 = w_acc && !r_ptr;
  assign w_wr1 = (w_acc && r_ptr) || w_pad;
  assign w_ovf0 = bus.credit_ret0 && !w_wr0 && r_cred0 == CMAX;
  assign w_ovf1 = bus.credit_ret1 && !w_wr1 && r_cred1 == CMAX;
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt = r_ptr;
    w_pad = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = &bus.lane_en ? STRIPE : |bus.lane_en ? SINGLE : IDLE;
        w_ptr_nxt = bus.lane_en == 2'b10;
      end
      STRIPE: begin
        if (w_acc) w_ptr_nxt = ~r_ptr;
        else if (!bus.valid_in && !r_ptr) w_state_nxt = IDLE;
`ifdef STRIPE_PAD_EN
        else if (!bus.valid_in) w_state_nxt = FLUSH;
`endif
      end
      SINGLE: w_state_nxt = bus.valid_in ? SINGLE : IDLE;
`ifdef STRIPE_PAD_EN
      FLUSH: if (|r_cred1) begin
        w_pad = 1'b1;
        w_ptr_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_ptr <= 1'b0;
      r_cred0 <= CMAX;
      r_cred1 <= CMAX;
      r_wr0 <= 1'b0;
      r_wr1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
      r_pad <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
      r_cred0 <= cred_nxt(r_cred0, w_wr0, bus.credit_ret0);
      r_cred1 <= cred_nxt(r_cred1, w_wr1, bus.credit_ret1);
      r_wr0 <= w_wr0;
      r_wr1 <= w_wr1;
      if (w_wr0) r_d0 <= bus.data_in;
      if (w_wr1) r_d1 <= w_pad ? PAD_WORD : bus.data_in;
      r_pad <= w_pad;
      r_err <= r_err | w_ovf0 | w_ovf1;
    end
  end
  assign bus.ready_out = w_ready;
  assign bus.wr_en0 = r_wr0;
  assign bus.wr_en1 = r_wr1;
  assign bus.data_out0 = r_d0;
  assign bus.data_out1 = r_d1;
  assign bus.pad_out = r_pad;
  assign bus.err_credit = r_err;
endmodule

// File: tb/tb_lane_stripe_sched.sv
// tb_lane_stripe_sched: table-driven cycle vectors plus a bounded start-up sequence for lane_stripe_sched
module tb_lane_stripe_sched;
`ifdef STRIPE_PAD_EN
  localparam logic PAD = 1'b1;
`else
  localparam logic PAD = 1'b0;
`endif
  localparam logic NP = !PAD;
  typedef struct {
    logic rst_l;
    logic v;
    logic [31:0] d;
    logic [1:0] en;
    logic c0;
    logic c1;
    logic er;
    logic ew0;
    logic ew1;
    logic [31:0] ed;
    logic ep;
    logic ee;
  } vec_t;
  logic clk = 1'b0;
  logic rst_l;
  int errors = 0;
  int checks = 0;
  vec_t tv[$];
  lane_stripe_if #(.DW(32)) bus();
  lane_stripe_sched #(.DW(32), .CREDITS(4), .PAD_WORD(32'hBCBCBCBC)) dut (
    .clk_2f(clk),
    .reset_L(rst_l),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, v, input logic [31:0] d, input logic [1:0] en,
                     input logic c0, c1, er, ew0, ew1, input logic [31:0] ed, input logic ep, ee);
    vec_t x;
    x.rst_l = r; x.v = v; x.d = d; x.en = en; x.c0 = c0; x.c1 = c1;
    x.er = er; x.ew0 = ew0; x.ew1 = ew1; x.ed = ed; x.ep = ep; x.ee = ee;
    tv.push_back(x);
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bit seen;
    // reset held with valid high, then a four-word stripe
    add(0,1,32'hDEADBEEF,2'b11,0,0, 0,0,0,0,0,0);
    add(0,1,32'hDEADBEEF,2'b11,0,0, 0,0,0,0,0,0);
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'hAAAAAAAA,2'b11,0,0, 1,1,0,32'hAAAAAAAA,0,0);
    add(1,1,32'hEEEEEEEE,2'b11,0,0, 1,0,1,32'hEEEEEEEE,0,0);
    add(1,1,32'hCCCCCCCC,2'b11,0,0, 1,1,0,32'hCCCCCCCC,0,0);
    add(1,1,32'h11111111,2'b11,0,0, 1,0,1,32'h11111111,0,0);
    add(1,0,0,2'b11,0,0, 1,0,0,0,0,0);
    // refill to 4/4 in IDLE, then backpressure with 10 words
    add(1,0,0,2'b00,1,1, 0,0,0,0,0,0);
    add(1,0,0,2'b00,1,1, 0,0,0,0,0,0);
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    for (int k = 1; k <= 8; k++)
      add(1,1,32'h100 + k,2'b11,0,0, 1,k[0],!k[0],32'h100 + k,0,0);
    add(1,1,32'h109,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h109,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h109,2'b11,1,0, 0,0,0,0,0,0);
    add(1,1,32'h109,2'b11,0,0, 1,1,0,32'h109,0,0);
    add(1,1,32'h10A,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h10A,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h10A,2'b11,0,1, 0,0,0,0,0,0);
    add(1,1,32'h10A,2'b11,0,0, 1,0,1,32'h10A,0,0);
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    for (int k = 0; k < 4; k++) add(1,0,0,2'b00,1,1, 0,0,0,0,0,0);
    // overflow is sticky; write+return on lane 0 leaves the counter at 4
    add(1,0,0,2'b00,1,0, 0,0,0,0,0,1);
    add(1,0,0,2'b00,0,0, 0,0,0,0,0,1);
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,1);
    add(1,1,32'h55,2'b11,1,0, 1,1,0,32'h55,0,1);
    for (int k = 0; k < 8; k++)
      add(1,1,32'h200 + k,2'b11,0,0, 1,k[0],!k[0],32'h200 + k,0,1);
    add(1,1,32'h208,2'b11,0,0, 0,0,0,0,0,1);
    add(1,1,32'h208,2'b11,0,1, 0,0,0,0,0,1);
    add(1,1,32'h208,2'b11,0,0, 1,0,1,32'h208,0,1);
    add(1,1,32'h209,2'b11,0,0, 0,0,0,0,0,1);
    add(0,1,32'h209,2'b11,0,0, 0,0,0,0,0,0);
    // single lane 1; lane_en change mid-burst ignored; then single lane 0
    add(1,0,0,2'b10,0,0, 0,0,0,0,0,0);
    add(1,1,32'hFFFFFFFF,2'b10,0,0, 1,0,1,32'hFFFFFFFF,0,0);
    add(1,1,32'hAAAAAAAA,2'b01,0,0, 1,0,1,32'hAAAAAAAA,0,0);
    add(1,0,0,2'b01,0,0, 1,0,0,0,0,0);
    add(1,0,0,2'b01,0,0, 0,0,0,0,0,0);
    add(1,1,32'h77,2'b01,0,0, 1,1,0,32'h77,0,0);
    add(1,0,0,2'b11,0,0, 1,0,0,0,0,0);
    // open pair: padded close, or pointer held at lane 1 without padding
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h99999999,2'b11,0,0, 1,1,0,32'h99999999,0,0);
    add(1,0,0,2'b11,0,0, 1,0,0,0,0,0);
    add(1,0,0,2'b11,0,0, NP,0,PAD,32'hBCBCBCBC,PAD,0);
    add(1,0,0,2'b00,0,0, NP,0,0,0,0,0);
    add(1,1,32'h12,2'b00,0,0, NP,0,NP,32'h12,0,0);
    add(1,0,0,2'b00,0,0, NP,0,0,0,0,0);
    // reset mid-pair clears the pending pointer; next word lands on lane 0
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h31,2'b11,0,0, 1,1,0,32'h31,0,0);
    add(0,1,32'h32,2'b11,0,0, 1,0,0,0,0,0);
    add(1,0,0,2'b11,0,0, 0,0,0,0,0,0);
    add(1,1,32'h33,2'b11,0,0, 1,1,0,32'h33,0,0);
    add(0,0,0,2'b11,0,0, 1,0,0,0,0,0);
    rst_l = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.lane_en = 2'b00;
    bus.credit_ret0 = 1'b0;
    bus.credit_ret1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    foreach (tv[i]) begin
      rst_l = tv[i].rst_l;
      bus.valid_in = tv[i].v;
      bus.data_in = tv[i].d;
      bus.lane_en = tv[i].en;
      bus.credit_ret0 = tv[i].c0;
      bus.credit_ret1 = tv[i].c1;
      #1;
      chk("ready", i, 32'(bus.ready_out), 32'(tv[i].er));
      @(posedge clk);
      #1;
      chk("wr0_wr1_pad_err", i, 32'({bus.wr_en0, bus.wr_en1, bus.pad_out, bus.err_credit}),
          32'({tv[i].ew0, tv[i].ew1, tv[i].ep, tv[i].ee}));
      if (tv[i].ew0) chk("data0", i, bus.data_out0, tv[i].ed);
      if (tv[i].ew1) chk("data1", i, bus.data_out1, tv[i].ed);
      @(negedge clk);
    end
    // no lanes enabled: IDLE holds ready low even with valid high
    rst_l = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in = 32'h4444;
    bus.lane_en = 2'b00;
    bus.credit_ret0 = 1'b0;
    bus.credit_ret1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("idle_ready", k, 32'(bus.ready_out), 32'd0);
      @(negedge clk);
      chk("idle_wr", k, 32'({bus.wr_en0, bus.wr_en1}), 32'd0);
    end
    // enabling both lanes must raise ready within a bounded wait, then stripe starts on lane 0
    bus.lane_en = 2'b11;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = bus.ready_out;
    end
    chk("ready_after_enable", 0, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    chk("first_stripe_lanes", 0, 32'({bus.wr_en0, bus.wr_en1}), 32'b10);
    chk("first_stripe_data", 0, bus.data_out0, 32'h4444);
    @(negedge clk);
    bus.data_in = 32'h5555;
    @(posedge clk);
    #1;
    chk("second_stripe_lanes", 0, 32'({bus.wr_en0, bus.wr_en1}), 32'b01);
    chk("second_stripe_data", 0, bus.data_out1, 32'h5555);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
